// File: rtl/datapath_pkg.sv
// Shared encodings for the self-sequenced datapath: command opcodes, shift codes and FSM states.
package datapath_pkg;

    typedef enum logic [2:0] {
        OP_MOV_IMM = 3'b000,
        OP_MOV_REG = 3'b001,
        OP_ADD     = 3'b010,
        OP_CMP     = 3'b011,
        OP_AND     = 3'b100,
        OP_MVN     = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        SH_NONE = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADA,
        S_LOADB,
        S_EXEC,
        S_WB
    } state_e;

    // MOV_IMM and the illegal codes 11x go straight from idle to writeback.
    function automatic logic skips_alu(input logic [2:0] op);
        return (op == OP_MOV_IMM) || (op[2:1] == 2'b11);
    endfunction

    function automatic logic writes_rd(input logic [2:0] op);
        return (op == OP_MOV_IMM) || (op == OP_MOV_REG) || (op == OP_ADD) ||
               (op == OP_AND) || (op == OP_MVN);
    endfunction

endpackage

// File: rtl/datapath_regfile.sv
// Register file: NUM_REGS x DATA_WIDTH, one synchronous write port, one combinational read port.
module datapath_regfile #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int REG_AW     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [REG_AW-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_AW-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata = regs[raddr];

endmodule

// File: rtl/datapath_seq.sv
// Self-sequenced datapath: valid/ready command in, regfile -> A/B -> shift/ALU -> C -> writeback, done pulse.
// Optional N/V flag logic is enabled by defining DATAPATH_SEQ_NV_FLAGS_EN.
module datapath_seq
    import datapath_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 8,
    parameter int REG_AW     = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [REG_AW-1:0]     cmd_rd,
    input  logic [REG_AW-1:0]     cmd_rn,
    input  logic [REG_AW-1:0]     cmd_rm,
    input  logic [1:0]            cmd_shift,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] datapath_out,
    output logic                  Z_out,
    output logic                  N_out,
    output logic                  V_out
);

    localparam int MSB = DATA_WIDTH - 1;

    state_e                state;
    logic                  ready_q;
    logic [2:0]            op_q;
    logic [REG_AW-1:0]     rd_q, rn_q, rm_q;
    shift_e                sh_q;
    logic [DATA_WIDTH-1:0] imm_q, a_q, b_q, c_q;
    logic                  z_q;

    logic                  rf_we;
    logic [REG_AW-1:0]     rf_raddr;
    logic [DATA_WIDTH-1:0] rf_wdata, rf_rdata;
    logic [DATA_WIDTH-1:0] bs, alu_res;

    // Single read port: rn is addressed while loading A, rm while loading B.
    assign rf_raddr = (state == S_LOADB) ? rm_q : rn_q;
    assign rf_we    = (state == S_WB) && writes_rd(op_q);
    assign rf_wdata = (op_q == OP_MOV_IMM) ? imm_q : c_q;

    datapath_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .REG_AW     (REG_AW)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (rf_we),
        .waddr   (rd_q),
        .wdata   (rf_wdata),
        .raddr   (rf_raddr),
        .rdata   (rf_rdata)
    );

    always_comb begin
        case (sh_q)
            SH_LSL:  bs = {b_q[MSB-1:0], 1'b0};
            SH_LSR:  bs = {1'b0, b_q[MSB:1]};
            SH_ASR:  bs = {b_q[MSB], b_q[MSB:1]};
            default: bs = b_q;
        endcase
    end

    always_comb begin
        alu_res = bs;
        case (op_q)
            OP_ADD:  alu_res = a_q + bs;
            OP_CMP:  alu_res = a_q - bs;
            OP_AND:  alu_res = a_q & bs;
            OP_MVN:  alu_res = ~bs;
            default: alu_res = bs;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            done    <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            sh_q    <= SH_NONE;
            imm_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            z_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        rd_q    <= cmd_rd;
                        rn_q    <= cmd_rn;
                        rm_q    <= cmd_rm;
                        sh_q    <= shift_e'(cmd_shift);
                        imm_q   <= cmd_imm;
                        ready_q <= 1'b0;
                        if (skips_alu(cmd_op)) begin
                            state <= S_WB;
                            done  <= 1'b1;
                        end else begin
                            state <= S_LOADA;
                        end
                    end
                end
                S_LOADA: begin
                    a_q   <= rf_rdata;
                    state <= S_LOADB;
                end
                S_LOADB: begin
                    b_q   <= rf_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (op_q != OP_CMP) begin
                        c_q <= alu_res;
                    end
                    z_q   <= (alu_res == '0);
                    state <= S_WB;
                    done  <= 1'b1;
                end
                S_WB: begin
                    if (op_q == OP_MOV_IMM) begin
                        c_q <= imm_q;
                    end
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DATAPATH_SEQ_NV_FLAGS_EN
    logic alu_v, n_q, v_q;

    always_comb begin
        alu_v = 1'b0;
        case (op_q)
            OP_ADD:  alu_v = (a_q[MSB] == bs[MSB]) && (alu_res[MSB] != a_q[MSB]);
            OP_CMP:  alu_v = (a_q[MSB] != bs[MSB]) && (alu_res[MSB] != a_q[MSB]);
            default: alu_v = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else if (state == S_EXEC) begin
            n_q <= alu_res[MSB];
            v_q <= alu_v;
        end
    end

    assign N_out = n_q;
    assign V_out = v_q;
`else
    assign N_out = 1'b0;
    assign V_out = 1'b0;
`endif

    assign cmd_ready    = ready_q;
    assign datapath_out = c_q;
    assign Z_out        = z_q;

endmodule
